// File: rtl/stream_acc_reduce.sv
// Token-stream reduction stage: sums groups of LEN tokens into one result.
// Supports early flush of a partial group; EN freezes all state.
module stream_acc_reduce #(
   parameter int N     = 16,
   parameter int LEN   = 8,
   parameter int ACC_W = 24
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             EN,
   input  logic             R_IN,
   input  logic [N-1:0]     D_IN,
   input  logic             FLUSH,
   output logic             R_OUT,
   output logic [ACC_W-1:0] D_OUT,
   output logic             BUSY
);

   typedef enum logic {IDLE, ACCUM} state_t;

   localparam logic [7:0] LAST = 8'(LEN - 1);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_nxt;
   logic [ACC_W-1:0] dout_nxt;
   logic [ACC_W-1:0] sum;
   logic [7:0]       cnt;
   logic [7:0]       cnt_nxt;
   logic             rout_nxt;
   state_t           state;

   assign state = (cnt == 8'd0) ? IDLE : ACCUM;
   assign BUSY  = (state == ACCUM);
   assign sum   = acc + ACC_W'(D_IN);

   always_comb begin
      acc_nxt  = acc;
      cnt_nxt  = cnt;
      dout_nxt = D_OUT;
      rout_nxt = 1'b0;
      if (R_IN) begin
         if (cnt == LAST || FLUSH) begin
            dout_nxt = sum;
            rout_nxt = 1'b1;
            acc_nxt  = '0;
            cnt_nxt  = '0;
         end else begin
            acc_nxt = sum;
            cnt_nxt = cnt + 8'd1;
         end
      end else if (FLUSH) begin
         // an empty group never produces a token
         unique case (state)
            ACCUM: begin
               dout_nxt = acc;
               rout_nxt = 1'b1;
               acc_nxt  = '0;
               cnt_nxt  = '0;
            end
            IDLE: begin
               rout_nxt = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         acc   <= '0;
         cnt   <= '0;
         D_OUT <= '0;
         R_OUT <= 1'b0;
      end else if (EN) begin
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         D_OUT <= dout_nxt;
         R_OUT <= rout_nxt;
      end
   end

endmodule
